clock_group_reset_sequencer: RTL and testbench



---
 rtl/clock_group_reset_sequencer_pkg.sv | 27 ++
 rtl/clock_group_reset_sequencer_if.sv | 36 +++
 rtl/clock_group_reset_sequencer_member.sv | 71 +++++++
 rtl/clock_group_reset_sequencer.sv | 138 +++++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/clock_group_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkgrp_pkg
// Description : Shared state encoding and counter sizing for the clock group
//               reset sequencer and its per-member reset leaves.
// Revision    : 1.0 - initial release
// ============================================================================
package clkgrp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_gate    = 2'd0;
    localparam state_t c_st_hold    = 2'd1;
    localparam state_t c_st_release = 2'd2;
    localparam state_t c_st_run     = 2'd3;

    // Wide enough to hold the largest of the three phase lengths.
    function automatic int cnt_width(input int gate_c, input int hold_c, input int stag_c);
        int m;
        m = gate_c;
        if (hold_c > m) m = hold_c;
        if (stag_c > m) m = stag_c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_group_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_group_reset_sequencer_if
// Description : Group reset request, soft reset requests and the per-member
//               reset / clock-enable outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_group_reset_sequencer_if #(
    parameter int NUM_MEMBERS = 4
);
    logic                   in_reset;
    logic [NUM_MEMBERS-1:0] soft_reset_req;
    logic [NUM_MEMBERS-1:0] out_reset;
    logic [NUM_MEMBERS-1:0] out_clock_en;
    logic                   ready;
    logic                   busy;

    modport master (
        output in_reset,
        output soft_reset_req,
        input  out_reset,
        input  out_clock_en,
        input  ready,
        input  busy
    );

    modport slave (
        input  in_reset,
        input  soft_reset_req,
        output out_reset,
        output out_clock_en,
        output ready,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/clock_group_reset_sequencer_member.sv
`default_nettype none
// ============================================================================
// Module      : clock_group_member_reset
// Description : One member's registered reset and clock enable, with its own
//               soft reset hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_group_member_reset #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_group_reset,
    input  wire logic i_enable,
    input  wire logic i_release,
    input  wire logic i_soft_req,
    output logic      o_reset,
    output logic      o_clock_en,
    output logic      o_soft_active_d
);

    localparam logic [CNT_W-1:0] c_hold = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic             r_reset_q;
    logic             w_reset_d;
    logic             r_clock_en_q;
    logic             w_clock_en_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_reset_d    = r_reset_q;
        w_clock_en_d = r_clock_en_q;
        w_cnt_d      = r_cnt_q;
        if (i_enable)  w_clock_en_d = 1'b1;
        if (i_release) w_reset_d    = 1'b0;
        // A new request restarts the hold even mid-soft-reset.
        if (i_soft_req) begin
            w_cnt_d   = c_hold;
            w_reset_d = 1'b1;
        end else if (r_cnt_q != '0) begin
            w_cnt_d = r_cnt_q - c_one;
            if (r_cnt_q == c_one) w_reset_d = 1'b0;
        end
        if (i_group_reset) begin
            w_reset_d    = 1'b1;
            w_clock_en_d = 1'b0;
            w_cnt_d      = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_reset_q    <= 1'b1;
            r_clock_en_q <= 1'b0;
            r_cnt_q      <= '0;
        end else begin
            r_reset_q    <= w_reset_d;
            r_clock_en_q <= w_clock_en_d;
            r_cnt_q      <= w_cnt_d;
        end
    end

    assign o_reset         = r_reset_q;
    assign o_clock_en      = r_clock_en_q;
    assign o_soft_active_d = (w_cnt_d != '0);

endmodule
`default_nettype wire

// File: rtl/clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clock_group_reset_sequencer
// Description : Sequences gate / hold / staggered release of a clock group's
//               member resets and handles per-member soft resets in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_group_reset_sequencer
    import clkgrp_pkg::*;
#(
    parameter int NUM_MEMBERS    = 4,
    parameter int GATE_CYCLES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    clock_group_reset_sequencer_if.slave bus
);

    localparam int CW = cnt_width(GATE_CYCLES, HOLD_CYCLES, STAGGER_CYCLES);
    localparam int IW = $clog2(NUM_MEMBERS) + 1;

    localparam logic [CW-1:0] c_gate_last = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] c_hold_last = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] c_stag_last = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] c_ph_one    = CW'(1);
    localparam logic [IW-1:0] c_members   = IW'(NUM_MEMBERS);
    localparam logic [IW-1:0] c_idx_one   = IW'(1);

    state_t                 r_state_q;
    state_t                 w_state_d;
    logic [CW-1:0]          r_phase_q;
    logic [CW-1:0]          w_phase_d;
    logic [IW-1:0]          r_idx_q;
    logic [IW-1:0]          w_idx_d;
    logic                   r_ready_q;
    logic                   w_ready_d;
    logic                   r_busy_q;
    logic                   w_busy_d;
    logic                   w_enable;
    logic [NUM_MEMBERS-1:0] w_release;
    logic [NUM_MEMBERS-1:0] w_soft_req;
    logic [NUM_MEMBERS-1:0] w_soft_active_d;
    logic [NUM_MEMBERS-1:0] w_out_reset;
    logic [NUM_MEMBERS-1:0] w_out_clock_en;

    always_comb begin
        w_state_d = r_state_q;
        w_phase_d = r_phase_q;
        w_idx_d   = r_idx_q;
        w_enable  = 1'b0;
        w_release = '0;
        case (r_state_q)
            c_st_gate: begin
                if (r_phase_q == c_gate_last) begin
                    w_state_d = c_st_hold;
                    w_phase_d = '0;
                    w_enable  = 1'b1;
                end else begin
                    w_phase_d = r_phase_q + c_ph_one;
                end
            end
            c_st_hold: begin
                // Member 0 is released on the edge that enters RELEASE.
                if (r_phase_q == c_hold_last) begin
                    w_state_d    = c_st_release;
                    w_phase_d    = '0;
                    w_idx_d      = c_idx_one;
                    w_release[0] = 1'b1;
                end else begin
                    w_phase_d = r_phase_q + c_ph_one;
                end
            end
            c_st_release: begin
                if (r_idx_q == c_members) begin
                    w_state_d = c_st_run;
                    w_phase_d = '0;
                end else if (r_phase_q == c_stag_last) begin
                    for (int i = 0; i < NUM_MEMBERS; i++) begin
                        if (r_idx_q == IW'(i)) w_release[i] = 1'b1;
                    end
                    w_idx_d   = r_idx_q + c_idx_one;
                    w_phase_d = '0;
                end else begin
                    w_phase_d = r_phase_q + c_ph_one;
                end
            end
            default: begin
                w_state_d = r_state_q;
            end
        endcase
    end

    assign w_soft_req = bus.soft_reset_req & {NUM_MEMBERS{r_state_q == c_st_run}};
    assign w_ready_d  = (w_state_d == c_st_run) && !(|w_soft_active_d);
    assign w_busy_d   = (w_state_d != c_st_run);

    always_ff @(posedge clock) begin
        if (reset || bus.in_reset) begin
            r_state_q <= c_st_gate;
            r_phase_q <= '0;
            r_idx_q   <= '0;
            r_ready_q <= 1'b0;
            r_busy_q  <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_phase_q <= w_phase_d;
            r_idx_q   <= w_idx_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
        end
    end

    for (genvar g = 0; g < NUM_MEMBERS; g++) begin : g_member
        clock_group_member_reset #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CW)
        ) u_member (
            .clock           (clock),
            .reset           (reset),
            .i_group_reset   (bus.in_reset),
            .i_enable        (w_enable),
            .i_release       (w_release[g]),
            .i_soft_req      (w_soft_req[g]),
            .o_reset         (w_out_reset[g]),
            .o_clock_en      (w_out_clock_en[g]),
            .o_soft_active_d (w_soft_active_d[g])
        );
    end

    assign bus.out_reset    = w_out_reset;
    assign bus.out_clock_en = w_out_clock_en;
    assign bus.ready        = r_ready_q;
    assign bus.busy         = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_group_reset_sequencer
// Description : Scoreboard bench for the default 4-member sequencer and a
//               single-member, short-hold instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_group_reset_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clock_group_reset_sequencer_if #(.NUM_MEMBERS(4)) ifa();
    clock_group_reset_sequencer_if #(.NUM_MEMBERS(1)) ifb();

    clock_group_reset_sequencer #(
        .NUM_MEMBERS(4), .GATE_CYCLES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(8)
    ) u_dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ifa)
    );

    clock_group_reset_sequencer #(
        .NUM_MEMBERS(1), .GATE_CYCLES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
    ) u_dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (ifb)
    );

    typedef struct {
        int          cyc;
        int          tag;
        logic [31:0] rst_m;
        logic [31:0] en_m;
        logic        rdy;
        logic        bsy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    function automatic string tag_name(input int t);
        case (t)
            0: return "reset";
            1: return "powerup";
            2: return "inreset_pulse";
            3: return "inreset_mid_release";
            4: return "soft_in_hold_ignored";
            5: return "single_member";
            6: return "soft_member2";
            7: return "soft_rerequest";
            default: return "unknown";
        endcase
    endfunction

    // Output after the k-th edge since the last reset/in_reset edge.
    function automatic exp_t pw(input int k, input int n, input int g, input int h,
                                input int s, input int tag);
        exp_t        e;
        int          r;
        logic [31:0] full;
        full = (32'h1 << n) - 32'h1;
        r = 0;
        if (k >= g + h) r = (k - g - h) / s + 1;
        if (r > n) r = n;
        e.cyc   = cyc + 1;
        e.tag   = tag;
        e.rst_m = full & ~((32'h1 << r) - 32'h1);
        e.en_m  = (k < g) ? 32'h0 : full;
        e.rdy   = (k >= g + h + (n - 1) * s + 1);
        e.bsy   = !e.rdy;
        return e;
    endfunction

    function automatic exp_t mk(input int tag, input logic [31:0] r, input logic [31:0] en,
                                input logic rdy, input logic bsy);
        exp_t e;
        e.cyc = cyc + 1; e.tag = tag; e.rst_m = r; e.en_m = en; e.rdy = rdy; e.bsy = bsy;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input exp_t e, input string dut, input logic [31:0] r,
                         input logic [31:0] en, input logic rdy, input logic bsy);
        tests_run++;
        if (e.cyc != cyc || r !== e.rst_m || en !== e.en_m || rdy !== e.rdy || bsy !== e.bsy) begin
            tests_failed++;
            $display("FAIL %s/%s cyc=%0d: got out_reset=%h clock_en=%h ready=%b busy=%b, expected out_reset=%h clock_en=%h ready=%b busy=%b (due cyc %0d)",
                     dut, tag_name(e.tag), cyc, r, en, rdy, bsy, e.rst_m, e.en_m, e.rdy, e.bsy, e.cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            check(e, "A", {28'd0, ifa.out_reset}, {28'd0, ifa.out_clock_en}, ifa.ready, ifa.busy);
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            check(e, "B", {31'd0, ifb.out_reset}, {31'd0, ifb.out_clock_en}, ifb.ready, ifb.busy);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ifa.in_reset = 1'b0; ifa.soft_reset_req = 4'h0;
        ifb.in_reset = 1'b0; ifb.soft_reset_req = 1'b0;

        for (int i = 0; i < 3; i++) begin
            qa.push_back(pw(0, 4, 2, 16, 8, 0));
            qb.push_back(pw(0, 1, 2, 1, 1, 0));
            tick();
        end
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            qa.push_back(pw(k, 4, 2, 16, 8, 1));
            if (k <= 8) qb.push_back(pw(k, 1, 2, 1, 1, 5));
            tick();
        end

        // in_reset from RUN, then again while member 1 is just released
        ifa.in_reset = 1'b1;
        qa.push_back(pw(0, 4, 2, 16, 8, 2));
        tick();
        ifa.in_reset = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            qa.push_back(pw(k, 4, 2, 16, 8, 2));
            tick();
        end
        ifa.in_reset = 1'b1;
        qa.push_back(pw(0, 4, 2, 16, 8, 3));
        tick();
        ifa.in_reset = 1'b0;

        // Full restart with soft requests hammered while in HOLD
        for (int k = 1; k <= 50; k++) begin
            ifa.soft_reset_req = (k - 1 >= 2 && k - 1 < 18) ? 4'hF : 4'h0;
            qa.push_back(pw(k, 4, 2, 16, 8, 4));
            tick();
        end
        ifa.soft_reset_req = 4'h0;

        for (int j = 0; j < 20; j++) begin
            ifa.soft_reset_req = (j == 0) ? 4'b0100 : 4'h0;
            qa.push_back(mk(6, (j < 16) ? 32'h4 : 32'h0, 32'hF, (j >= 16), 1'b0));
            tick();
        end

        for (int j = 0; j < 30; j++) begin
            ifa.soft_reset_req = (j == 0 || j == 10) ? 4'b0001 : 4'h0;
            qa.push_back(mk(7, (j < 26) ? 32'h1 : 32'h0, 32'hF, (j >= 26), 1'b0));
            tick();
        end
        ifa.soft_reset_req = 4'h0;

        tick();
        tick();
        if (qa.size() != 0 || qb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d/%0d expected entries never compared, required 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
